// File: rtl/segway_pkg.sv
// Shared types and constants for the segway serial front end.
// Holds the receiver FSM state encoding and the default bit-period divider.
package segway_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RECV  = 2'd2
  } rx_state_t;

  // 50 MHz system clock / 19200 baud
  localparam int BAUD_DIV_DEFAULT = 2604;

  localparam int DATA_BITS = 8;

  localparam logic [3:0] STOP_IDX = 4'(DATA_BITS);

  function automatic int cnt_width(input int div);
    return $clog2(div + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// The reset value is a parameter so idle-high lines come out of reset idle.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at half a bit, LSB-first data,
// stop-bit check, sticky rdy handshake with overrun and framing-error pulses.
module uart_rx
  import segway_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr
);

  localparam int CNT_W = cnt_width(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_DIV);
  localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(BAUD_DIV);

  rx_state_t state;
  rx_state_t next_state;

  logic                 rx_s;
  logic                 rx_prev;
  logic                 fall_edge;
  logic [CNT_W-1:0]     baud_cnt;
  logic                 baud_done;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  logic load_half;
  logic load_baud;
  logic clr_bits;
  logic shift_en;
  logic stop_ok;
  logic stop_bad;

  sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (RX),
    .q    (rx_s)
  );

  assign fall_edge = rx_prev & ~rx_s;

  // Loading N and acting on the count-of-1 cycle gives exactly N cycles per interval.
  assign baud_done = (baud_cnt <= CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_half  = 1'b0;
    load_baud  = 1'b0;
    clr_bits   = 1'b0;
    shift_en   = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (fall_edge) begin
          next_state = START;
          load_half  = 1'b1;
        end
      end
      START: begin
        if (baud_done) begin
          if (rx_s) begin
            next_state = IDLE;
          end else begin
            next_state = RECV;
            load_baud  = 1'b1;
            clr_bits   = 1'b1;
          end
        end
      end
      RECV: begin
        if (baud_done) begin
          if (bit_cnt == STOP_IDX) begin
            next_state = IDLE;
            stop_ok    = rx_s;
            stop_bad   = ~rx_s;
          end else begin
            shift_en  = 1'b1;
            load_baud = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_prev   <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '1;
    end else begin
      rx_prev <= rx_s;

      if (load_half) begin
        baud_cnt <= HALF_LOAD;
      end else if (load_baud) begin
        baud_cnt <= BAUD_LOAD;
      end else if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - 1'b1;
      end

      if (clr_bits) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (shift_en) begin
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      end
    end
  end

  // A completing byte outranks a same-cycle clear, so clr_rdy only acts when no byte lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      frm_err <= stop_bad;
      ovr     <= stop_ok & rdy & ~clr_rdy;
      if (stop_ok) begin
        rx_data <= shift_reg;
        rdy     <= 1'b1;
      end else if (clr_rdy) begin
        rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one task per scenario, inline comparisons,
// a bench-side serial transmitter and a negedge monitor counting output events.
module tb_uart_rx;

  // HALF_DIV is stretched past 500 so a 500-cycle low pulse still reads as a glitch.
  localparam int BAUD    = 800;
  localparam int HALF    = 520;
  localparam int LAT_NOM = 2 + HALF + 9 * BAUD;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       RX      = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr;

  int pass_cnt  = 0;
  int check_cnt = 0;

  int cycle          = 0;
  int start_cycle    = 0;
  int rdy_rise_cycle = 0;
  int rdy_rise_cnt   = 0;
  int ovr_cnt        = 0;
  int frm_cnt        = 0;
  int long_pulse_cnt = 0;
  logic rdy_q = 1'b0;
  logic ovr_q = 1'b0;
  logic frm_q = 1'b0;

  uart_rx #(
    .BAUD_DIV(BAUD),
    .HALF_DIV(HALF)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy),
    .frm_err(frm_err),
    .ovr    (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (rdy === 1'b1 && rdy_q !== 1'b1) begin
      rdy_rise_cnt++;
      rdy_rise_cycle = cycle;
    end
    if (ovr === 1'b1) ovr_cnt++;
    if (frm_err === 1'b1) frm_cnt++;
    if ((ovr === 1'b1 && ovr_q === 1'b1) || (frm_err === 1'b1 && frm_q === 1'b1)) long_pulse_cnt++;
    rdy_q = rdy;
    ovr_q = ovr;
    frm_q = frm_err;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    RX = 1'b0;
    start_cycle = cycle;
    wait_cycles(BAUD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_cycles(BAUD);
    end
    RX = stop_bit;
    wait_cycles(BAUD);
    RX = 1'b1;
  endtask

  task automatic clear_rdy();
    clr_rdy = 1'b1;
    wait_cycles(1);
    clr_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RX    = 1'b1;
    wait_cycles(5);
    @(negedge clk);
    check_cnt++;
    if (rx_data !== 8'h00) $display("[TB] FAIL reset_rx_data: got %h, expected 00", rx_data);
    else pass_cnt++;
    check_cnt++;
    if (rdy !== 1'b0) $display("[TB] FAIL reset_rdy: got %b, expected 0", rdy);
    else pass_cnt++;
    check_cnt++;
    if (frm_err !== 1'b0 || ovr !== 1'b0)
      $display("[TB] FAIL reset_pulses: got frm_err=%b ovr=%b, expected 0 0", frm_err, ovr);
    else pass_cnt++;
    rst_n = 1'b1;
    wait_cycles(20);
    clear_rdy();
    @(negedge clk);
    check_cnt++;
    if (rdy !== 1'b0) $display("[TB] FAIL idle_clr_rdy: got rdy=%b, expected 0", rdy);
    else pass_cnt++;
  endtask

  task automatic test_single_byte();
    int lat;
    int rise0 = rdy_rise_cnt;
    int ovr0  = ovr_cnt;
    int frm0  = frm_cnt;
    send_byte(8'h67, 1'b1);
    wait_cycles(10);
    @(negedge clk);
    check_cnt++;
    if (rx_data !== 8'h67) $display("[TB] FAIL single_data: got %h, expected 67", rx_data);
    else pass_cnt++;
    check_cnt++;
    if (rdy !== 1'b1 || rdy_rise_cnt != rise0 + 1)
      $display("[TB] FAIL single_rdy: got rdy=%b rises=%0d, expected 1 %0d", rdy, rdy_rise_cnt - rise0, 1);
    else pass_cnt++;
    lat = rdy_rise_cycle - start_cycle;
    check_cnt++;
    if (lat < LAT_NOM - 2 || lat > LAT_NOM + 2)
      $display("[TB] FAIL single_latency: got %0d, expected %0d..%0d", lat, LAT_NOM - 2, LAT_NOM + 2);
    else pass_cnt++;
    check_cnt++;
    if (ovr_cnt != ovr0 || frm_cnt != frm0)
      $display("[TB] FAIL single_pulses: got ovr=%0d frm=%0d, expected 0 0", ovr_cnt - ovr0, frm_cnt - frm0);
    else pass_cnt++;
    clear_rdy();
    @(negedge clk);
    check_cnt++;
    if (rdy !== 1'b0) $display("[TB] FAIL single_clr: got rdy=%b, expected 0", rdy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ovr0 = ovr_cnt;
    send_byte(8'h73, 1'b1);
    @(negedge clk);
    check_cnt++;
    if (rx_data !== 8'h73 || rdy !== 1'b1 || ovr_cnt != ovr0)
      $display("[TB] FAIL b2b_first: got data=%h rdy=%b ovr=%0d, expected 73 1 0", rx_data, rdy, ovr_cnt - ovr0);
    else pass_cnt++;
    send_byte(8'h41, 1'b1);
    wait_cycles(10);
    @(negedge clk);
    check_cnt++;
    if (ovr_cnt != ovr0 + 1 || long_pulse_cnt != 0)
      $display("[TB] FAIL b2b_ovr: got pulses=%0d long=%0d, expected 1 0", ovr_cnt - ovr0, long_pulse_cnt);
    else pass_cnt++;
    check_cnt++;
    if (rx_data !== 8'h41 || rdy !== 1'b1)
      $display("[TB] FAIL b2b_second: got data=%h rdy=%b, expected 41 1", rx_data, rdy);
    else pass_cnt++;
    clear_rdy();
  endtask

  task automatic test_glitch();
    int rise0 = rdy_rise_cnt;
    int frm0  = frm_cnt;
    @(posedge clk);
    #1;
    RX = 1'b0;
    wait_cycles(500);
    RX = 1'b1;
    wait_cycles(1000);
    @(negedge clk);
    check_cnt++;
    if (rdy !== 1'b0 || rdy_rise_cnt != rise0 || rx_data !== 8'h41)
      $display("[TB] FAIL glitch_outputs: got rdy=%b rises=%0d data=%h, expected 0 0 41", rdy, rdy_rise_cnt - rise0, rx_data);
    else pass_cnt++;
    check_cnt++;
    if (frm_cnt != frm0) $display("[TB] FAIL glitch_frm: got %0d pulses, expected 0", frm_cnt - frm0);
    else pass_cnt++;
    send_byte(8'h55, 1'b1);
    wait_cycles(10);
    @(negedge clk);
    check_cnt++;
    if (rx_data !== 8'h55 || rdy !== 1'b1 || frm_cnt != frm0)
      $display("[TB] FAIL glitch_follow: got data=%h rdy=%b frm=%0d, expected 55 1 0", rx_data, rdy, frm_cnt - frm0);
    else pass_cnt++;
    clear_rdy();
  endtask

  task automatic test_frame_error();
    int frm0  = frm_cnt;
    int rise0 = rdy_rise_cnt;
    int ovr0  = ovr_cnt;
    send_byte(8'hA5, 1'b0);
    wait_cycles(10);
    @(negedge clk);
    check_cnt++;
    if (frm_cnt != frm0 + 1 || long_pulse_cnt != 0)
      $display("[TB] FAIL ferr_pulse: got pulses=%0d long=%0d, expected 1 0", frm_cnt - frm0, long_pulse_cnt);
    else pass_cnt++;
    check_cnt++;
    if (rdy !== 1'b0 || rdy_rise_cnt != rise0 || ovr_cnt != ovr0)
      $display("[TB] FAIL ferr_rdy: got rdy=%b rises=%0d ovr=%0d, expected 0 0 0", rdy, rdy_rise_cnt - rise0, ovr_cnt - ovr0);
    else pass_cnt++;
    check_cnt++;
    if (rx_data !== 8'h55) $display("[TB] FAIL ferr_data: got %h, expected 55", rx_data);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'h3C;
    int rise0 = rdy_rise_cnt;
    int frm0  = frm_cnt;
    @(posedge clk);
    #1;
    RX = 1'b0;
    wait_cycles(BAUD);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      wait_cycles(BAUD);
    end
    RX = b[4];
    wait_cycles(BAUD / 2);
    rst_n = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    check_cnt++;
    if (rx_data !== 8'h00 || rdy !== 1'b0)
      $display("[TB] FAIL midrst_clear: got data=%h rdy=%b, expected 00 0", rx_data, rdy);
    else pass_cnt++;
    // The transmitter shares the system reset, so it drops the frame and idles high.
    rst_n = 1'b1;
    RX    = 1'b1;
    wait_cycles(6 * BAUD);
    @(negedge clk);
    check_cnt++;
    if (rdy_rise_cnt != rise0 || frm_cnt != frm0)
      $display("[TB] FAIL midrst_quiet: got rises=%0d frm=%0d, expected 0 0", rdy_rise_cnt - rise0, frm_cnt - frm0);
    else pass_cnt++;
    send_byte(8'h3C, 1'b1);
    wait_cycles(10);
    @(negedge clk);
    check_cnt++;
    if (rx_data !== 8'h3C || rdy !== 1'b1 || frm_cnt != frm0)
      $display("[TB] FAIL midrst_next: got data=%h rdy=%b frm=%0d, expected 3c 1 0", rx_data, rdy, frm_cnt - frm0);
    else pass_cnt++;
  endtask

  task automatic test_clr_collision();
    int ovr0 = ovr_cnt;
    @(negedge clk);
    check_cnt++;
    if (rdy !== 1'b1) $display("[TB] FAIL collide_pre_rdy: got %b, expected 1", rdy);
    else pass_cnt++;
    fork
      send_byte(8'h12, 1'b1);
      begin
        @(posedge clk);
        wait_cycles(2 + HALF + 9 * BAUD);
        clr_rdy = 1'b1;
        wait_cycles(1);
        clr_rdy = 1'b0;
      end
    join
    wait_cycles(5);
    @(negedge clk);
    check_cnt++;
    if (rdy !== 1'b1) $display("[TB] FAIL collide_rdy: got %b, expected 1", rdy);
    else pass_cnt++;
    check_cnt++;
    if (ovr_cnt != ovr0) $display("[TB] FAIL collide_ovr: got %0d pulses, expected 0", ovr_cnt - ovr0);
    else pass_cnt++;
    check_cnt++;
    if (rx_data !== 8'h12) $display("[TB] FAIL collide_data: got %h, expected 12", rx_data);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_clr_collision();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL be clocked by clk and use a single clock domain throughout.
REQ-002 The block SHALL use rst_n as a synchronous, active-low reset.
REQ-003 Parameters:
- BAUD_DIV, default 2604: clk cycles per bit (50 MHz / 19200 baud).
- HALF_DIV, default BAUD_DIV/2: delay from start-bit falling edge to the start-bit sample point.
REQ-004 Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- RX  input  1  asynchronous serial line, idles high.
- clr_rdy  input  1  consumer acknowledge; clears rdy.
- rx_data  output  8  last received byte.
- rdy  output  1  byte available; held until cleared.
- frm_err  output  1  one-cycle pulse; stop bit was sampled low.
- ovr  output  1  one-cycle pulse; a byte completed while rdy was still high.

Function
REQ-005 RX SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic SHALL use only the synchronized value (rx_s).
REQ-006 The FSM SHALL have three states: IDLE, START, RECV.
REQ-007 IDLE->START SHALL occur on an rx_s falling edge, which loads the baud counter with HALF_DIV.
REQ-008 In START, at counter expiry:
- rx_s==1: treat as a glitch, go to IDLE, no output change.
- rx_s==0: reload BAUD_DIV, clear the bit counter, go to RECV.
REQ-009 In RECV, the block SHALL sample rx_s every BAUD_DIV cycles into a shift register, LSB first, for 8 data bits; the 9th sample is the stop bit.
REQ-010 Bit counter width SHALL be 4 bits; the baud counter SHALL be sized ceil(log2(BAUD_DIV+1)) bits and count down.
REQ-011 Stop sample == 1:
- rx_data SHALL load the shift register and rdy SHALL be 1 on the next cycle.
- If rdy was already 1 and clr_rdy is not asserted in that cycle, ovr SHALL pulse for one cycle; rx_data is overwritten and rdy stays 1.
REQ-012 Stop sample == 0: frm_err SHALL pulse for one cycle; rx_data and rdy SHALL be unchanged.
REQ-013 After the stop sample the FSM SHALL return to IDLE; a falling edge on the very next cycle SHALL be accepted as a new start bit.
REQ-014 clr_rdy SHALL clear rdy on the next cycle; clr_rdy while rdy==0 has no effect.
REQ-015 When clr_rdy coincides with byte completion, set SHALL win: rdy==1 and no ovr.
REQ-016 Latency: rdy SHALL rise 2+HALF_DIV+9*BAUD_DIV (+/-2) cycles after the RX falling edge.
REQ-017 Falling edges of rx_s in START or RECV SHALL NOT restart the frame.

Reset
REQ-018 While rst_n==0 at a clk edge:
- State -> IDLE.
- rx_data -> 0x00; rdy, frm_err, ovr -> 0.
- Counters -> 0; synchronizer and shift register -> all ones.
REQ-019 Reset asserted mid-frame SHALL abandon the frame with no rdy and no frm_err.
REQ-020 After release, reception SHALL begin only at the next rx_s falling edge.

Structure
REQ-021 The FSM state enum (IDLE, START, RECV) and the BAUD_DIV default SHALL live in the shared package segway_pkg.
REQ-022 The 2-flop synchronizer SHALL be a sub-module named sync2 (parameterized reset value); everything else stays in uart_rx.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- uart_tx sends 0x67 ('g') -> rx_data==0x67, rdy==1 within REQ-016 window, frm_err==0, ovr==0.
- Send 0x73 then 0x41 back-to-back, no clr_rdy -> ovr pulses exactly once at the second completion, rx_data==0x41, rdy==1.
- RX low for 500 cycles then high -> FSM returns to IDLE; rdy, rx_data, frm_err unchanged; a following 0x55 frame is received correctly.
- Frame 0xA5 with stop bit forced 0 -> frm_err one-cycle pulse, rdy==0, rx_data keeps its prior value.
- rst_n low for 3 cycles during data bit 4 of 0x3C -> no rdy or frm_err; the next 0x3C is received correctly.
- clr_rdy asserted in the same cycle as 0x12 completion with rdy==1 -> rdy==1, ovr==0, rx_data==0x12.
